// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, drain replay, branch flush
// Optional feature macro: HAZARD_PERF_CNT_EN (builds the saturating stall performance counter)
module hazard_ctrl #(
  parameter int STALL_CYCLES = 2,
  parameter int REG_W        = 3
) (
  input  logic             CLK3,
  input  logic             RST,
  input  logic [REG_W-1:0] SRC_A,
  input  logic [REG_W-1:0] SRC_B,
  input  logic             SRC_A_VLD,
  input  logic             SRC_B_VLD,
  input  logic [REG_W-1:0] DST3,
  input  logic             WR3,
  input  logic [REG_W-1:0] DST4,
  input  logic             WR4,
  input  logic             BRANCH2,
  output logic             HOLD,
  output logic             PC_EN,
  output logic             FLUSH,
  output logic [7:0]       STALL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] LP_LOAD = 4'(STALL_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_hold;
  logic       r_pc_en;
  logic       r_flush;
  logic       w_hold_nxt;
  logic       w_pc_en_nxt;
  logic       w_flush_nxt;
  logic       w_hit_a;
  logic       w_hit_b;
  logic       w_hazard;

  // R0 is hardwired zero, so a match on index 0 never creates a dependency
  assign w_hit_a  = SRC_A_VLD && (SRC_A != '0) &&
                    ((WR3 && (SRC_A == DST3)) || (WR4 && (SRC_A == DST4)));
  assign w_hit_b  = SRC_B_VLD && (SRC_B != '0) &&
                    ((WR3 && (SRC_B == DST3)) || (WR4 && (SRC_B == DST4)));
  assign w_hazard = w_hit_a | w_hit_b;

  // Next-state and next-output decode; outputs are registered so they lag the decision by one edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = 1'b0;
    w_pc_en_nxt = 1'b1;
    w_flush_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (BRANCH2) begin
          w_flush_nxt = 1'b1;
        end else if (w_hazard) begin
          w_state_nxt = S_STALL;
          w_cnt_nxt   = LP_LOAD;
          w_hold_nxt  = 1'b1;
          w_pc_en_nxt = 1'b0;
        end
      end
      S_STALL: begin
        w_pc_en_nxt = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt  = r_cnt - 4'd1;
          w_hold_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, down-counter and output registers; reset aborts any stall in progress
  always_ff @(posedge CLK3) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hold  <= 1'b0;
      r_pc_en <= 1'b1;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_pc_en <= w_pc_en_nxt;
      r_flush <= w_flush_nxt;
    end
  end

  assign HOLD  = r_hold;
  assign PC_EN = r_pc_en;
  assign FLUSH = r_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [7:0] r_stall_cnt;
  logic       w_start;

  assign w_start = (r_state == S_IDLE) && !BRANCH2 && w_hazard;

  // Count stall entries, saturating at 255
  always_ff @(posedge CLK3) begin
    if (RST) begin
      r_stall_cnt <= 8'd0;
    end else if (w_start && (r_stall_cnt != 8'hFF)) begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign STALL_CNT = r_stall_cnt;
`else
  assign STALL_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with schedule-based reference model
module tb_hazard_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src_a, src_b, dst3, dst4;
  logic       src_a_vld, src_b_vld, wr3, wr4, branch2;
  logic       hold, pc_en, flush;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.STALL_CYCLES(S), .REG_W(3)) dut (
    .CLK3(clk), .RST(rst),
    .SRC_A(src_a), .SRC_B(src_b), .SRC_A_VLD(src_a_vld), .SRC_B_VLD(src_b_vld),
    .DST3(dst3), .WR3(wr3), .DST4(dst4), .WR4(wr4), .BRANCH2(branch2),
    .HOLD(hold), .PC_EN(pc_en), .FLUSH(flush), .STALL_CNT(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit src_hit(input logic [2:0] s, input logic v);
    return v && (s != 0) && ((wr3 && s == dst3) || (wr4 && s == dst4));
  endfunction

  // Reference model: a queue of scheduled output pairs {hold,pc_en};
  // an empty queue means the controller is free to sample events.
  logic [1:0] sched[$];
  bit         model_on = 0;
  bit         e_hold, e_pc, e_flush;
  int         e_cnt;

  always @(posedge clk) begin
    logic [1:0] o;
    if (rst) begin
      sched.delete();
      e_hold = 0; e_pc = 1; e_flush = 0; e_cnt = 0;
      model_on = 1;
    end else if (sched.size() != 0) begin
      o = sched.pop_front();
      e_hold = o[1]; e_pc = o[0]; e_flush = 0;
    end else if (branch2) begin
      e_hold = 0; e_pc = 1; e_flush = 1;
    end else if (src_hit(src_a, src_a_vld) || src_hit(src_b, src_b_vld)) begin
      for (int i = 0; i < S; i++) sched.push_back(2'b10);
      sched.push_back(2'b00);
      sched.push_back(2'b01);
      o = sched.pop_front();
      e_hold = o[1]; e_pc = o[0]; e_flush = 0;
      if (e_cnt < 255) e_cnt++;
    end else begin
      e_hold = 0; e_pc = 1; e_flush = 0;
    end
  end

  // Compare every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_hold", int'(hold), int'(e_hold));
      chk("m_pc_en", int'(pc_en), int'(e_pc));
      chk("m_flush", int'(flush), int'(e_flush));
`ifdef HAZARD_PERF_CNT_EN
      chk("m_stall_cnt", int'(stall_cnt), e_cnt);
`else
      chk("m_stall_cnt", int'(stall_cnt), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    src_a = 0; src_b = 0; dst3 = 0; dst4 = 0;
    src_a_vld = 0; src_b_vld = 0; wr3 = 0; wr4 = 0; branch2 = 0;
  endtask

  task automatic set_haz_a3();
    src_a = 3; src_a_vld = 1; wr3 = 1; dst3 = 3;
  endtask

  task automatic outs(input string name, input int h, input int p, input int f);
    chk({name, "_hold"}, int'(hold), h);
    chk({name, "_pc_en"}, int'(pc_en), p);
    chk({name, "_flush"}, int'(flush), f);
  endtask

  initial begin
    quiet();
    rst = 1;
    tick(); tick();
    outs("reset", 0, 1, 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    rst = 0;
    tick();
    outs("idle", 0, 1, 0);

    // Basic load-use stall on SRC_A vs stage 3
    set_haz_a3();
    tick(); outs("stall1", 1, 0, 0);
    quiet();
    tick(); outs("stall2", 1, 0, 0);
    tick(); outs("drain", 0, 0, 0);
    tick(); outs("resume", 0, 1, 0);

    // Write to R0 in stage 4 never stalls
    src_b = 0; src_b_vld = 1; wr4 = 1; dst4 = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); outs("r0", 0, 1, 0);
    end
    quiet();

    // Branch wins over a simultaneous hazard
    set_haz_a3(); branch2 = 1;
    tick(); outs("br", 0, 1, 1);
    quiet();
    tick(); outs("br_after", 0, 1, 0);

    // Reset during the second stall cycle aborts without a drain
    set_haz_a3();
    tick(); outs("rs_stall1", 1, 0, 0);
    quiet();
    tick(); outs("rs_stall2", 1, 0, 0);
    rst = 1;
    tick(); outs("rs_reset", 0, 1, 0);
    rst = 0;
    tick(); outs("rs_nodrain", 0, 1, 0);

    // Continuously held hazard: HOLD,HOLD,DRAIN,IDLE repeating
    set_haz_a3();
    for (int k = 0; k < 20; k++) begin
      tick();
      case (k % 4)
        0, 1:    outs("rep_hold", 1, 0, 0);
        2:       outs("rep_drain", 0, 0, 0);
        default: outs("rep_idle", 0, 1, 0);
      endcase
    end
    quiet();
    tick();

    // 300 stall entries saturate the performance counter
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 300; n++) begin
      src_b = 5; src_b_vld = 1; wr4 = 1; dst4 = 5;
      tick();
      quiet();
      for (int j = 0; j < S + 1; j++) tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_sat", int'(stall_cnt), 255);
`else
    chk("perf_off", int'(stall_cnt), 0);
`endif

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      branch2   = ($urandom_range(0, 6) == 0);
      src_a     = 3'($urandom_range(0, 3));
      src_b     = 3'($urandom_range(0, 3));
      dst3      = 3'($urandom_range(0, 3));
      dst4      = 3'($urandom_range(0, 3));
      src_a_vld = 1'($urandom_range(0, 1));
      src_b_vld = 1'($urandom_range(0, 1));
      wr3       = 1'($urandom_range(0, 1));
      wr4       = 1'($urandom_range(0, 1));
      tick();
    end
    quiet();
    rst = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
